// File: rtl/s_sprite_pkg.sv
// Shared display package for the S_* screen blocks.
// Holds the vgac scan widths and types, the default background and
// transparent-key colours, the blink FSM state type and a pixel opacity helper.
package s_sprite_pkg;

   localparam int SCR_X_W = 10;  // vgac scan x width
   localparam int SCR_Y_W = 9;   // vgac scan y width
   localparam int CMP_X_W = 11;  // x compares carry one extra bit so slots past 1023 never wrap

   localparam logic [11:0] COLOR_BG  = 12'hfff;
   localparam logic [11:0] COLOR_KEY = 12'h0f0;

   typedef logic [SCR_X_W-1:0] scan_x_t;
   typedef logic [SCR_Y_W-1:0] scan_y_t;

   typedef struct packed {
      scan_x_t x;
      scan_y_t y;
   } scan_t;

   typedef enum logic {
      BLK_IDLE  = 1'b0,
      BLK_BLINK = 1'b1
   } blink_state_t;

   function automatic logic px_opaque(input logic [11:0] px, input logic [11:0] key);
      return px != key;
   endfunction

endpackage

// File: rtl/s_sprite_blink.sv
// Blink controller for the lives bar.
// Watches the clamped count every clock; when it drops, the slot that was
// lost blinks for BLINK_LEN frame ticks before disappearing for good.
// Ports:
//   clk_i, rst_i      pixel clock, asynchronous active-high reset
//   count_c_i         clamped copy count
//   frame_tick_i      one-clock pulse per video frame
//   blink_slot_o      index of the slot being blinked
//   blink_active_o    FSM is in the blinking state
//   blink_on_o        current blink phase draws the slot
module s_sprite_blink
   import s_sprite_pkg::*;
#(
   parameter int CNT_W      = 3,
   parameter int BLINK_LEN  = 60,
   parameter int BLINK_HALF = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CNT_W-1:0] count_c_i,
   input  logic             frame_tick_i,
   output logic [CNT_W-1:0] blink_slot_o,
   output logic             blink_active_o,
   output logic             blink_on_o
);

   localparam int BC_W = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_LEN - 1);
   localparam logic [BC_W-1:0] BC_HALF = BC_W'(BLINK_HALF);

   blink_state_t     state_q, state_d;
   logic [CNT_W-1:0] blink_slot_q, blink_slot_d;
   logic [CNT_W-1:0] prev_count_q, prev_count_d;
   logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic [BC_W-1:0]  phase;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= BLK_IDLE;
         blink_slot_q <= '0;
         prev_count_q <= '0;
         blink_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         blink_slot_q <= blink_slot_d;
         prev_count_q <= prev_count_d;
         blink_cnt_q  <= blink_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      blink_slot_d = blink_slot_q;
      blink_cnt_d  = blink_cnt_q;
      prev_count_d = count_c_i;
      unique case (state_q)
         BLK_IDLE: begin
            if (count_c_i < prev_count_q) begin
               state_d      = BLK_BLINK;
               blink_slot_d = prev_count_q - CNT_W'(1);
               blink_cnt_d  = '0;
            end
         end
         BLK_BLINK: begin
            if (count_c_i < prev_count_q) begin
               // another life lost mid-blink: blink the newly lost slot from the start
               blink_slot_d = prev_count_q - CNT_W'(1);
               blink_cnt_d  = '0;
            end else if (count_c_i > prev_count_q && count_c_i > blink_slot_q) begin
               // slot has been refilled, it is drawn solid by the count itself
               state_d     = BLK_IDLE;
               blink_cnt_d = '0;
            end else if (frame_tick_i) begin
               if (blink_cnt_q == BC_LAST) begin
                  state_d     = BLK_IDLE;
                  blink_cnt_d = '0;
               end else begin
                  blink_cnt_d = blink_cnt_q + BC_W'(1);
               end
            end
         end
         default: state_d = BLK_IDLE;
      endcase
   end

   assign phase          = blink_cnt_q / BC_HALF;
   assign blink_on_o     = ~phase[0];
   assign blink_slot_o   = blink_slot_q;
   assign blink_active_o = (state_q == BLK_BLINK);

endmodule

// File: rtl/s_sprite_array.sv
// Lives/hearts bar: draws 0..MAX_COUNT copies of one animated sprite in a
// row starting at (posx_i, posy_i) on the vgac scan, with a transparent key
// colour and a blink on the slot lost when the count drops.
// Ports:
//   clk_i, rst_i      pixel clock, asynchronous active-high reset
//   x_i, y_i          vgac scan position
//   posx_i, posy_i    top-left corner of slot 0
//   count_i           copies to show (clamped to MAX_COUNT)
//   enable_i          0 hides the whole row
//   frame_tick_i      one-clock pulse per video frame
//   rom_addr_o        registered sprite ROM address
//   rom_data_i        sprite ROM word for rom_addr_o (colour in [15:4])
//   color_o           pixel colour, two clocks after x_i/y_i
//   is_display_o      color_o is an opaque sprite pixel
module s_sprite_array
   import s_sprite_pkg::*;
#(
   parameter int          SPR_W      = 45,
   parameter int          SPR_H      = 43,
   parameter int          GAP        = 4,
   parameter int          MAX_COUNT  = 5,
   parameter int          CNT_W      = 3,
   parameter int          NFRAMES    = 2,
   parameter int          ANIM_DIV   = 15,
   parameter int          BLINK_LEN  = 60,
   parameter int          BLINK_HALF = 8,
   parameter logic [11:0] KEY        = COLOR_KEY,
   parameter logic [11:0] BG         = COLOR_BG,
   parameter int          ADDR_W     = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [SCR_X_W-1:0] x_i,
   input  logic [SCR_Y_W-1:0] y_i,
   input  logic [SCR_X_W-1:0] posx_i,
   input  logic [SCR_Y_W-1:0] posy_i,
   input  logic [CNT_W-1:0]   count_i,
   input  logic               enable_i,
   input  logic               frame_tick_i,
   output logic [ADDR_W-1:0]  rom_addr_o,
   input  logic [15:0]        rom_data_i,
   output logic [11:0]        color_o,
   output logic               is_display_o
);

   localparam int PITCH = SPR_W + GAP;
   localparam int FRM_W = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
   localparam int ANC_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic [CMP_X_W-1:0] SPR_W_X  = CMP_X_W'(SPR_W);
   localparam logic [SCR_Y_W-1:0] SPR_H_Y  = SCR_Y_W'(SPR_H);
   localparam logic [ADDR_W-1:0]  SPR_W_A  = ADDR_W'(SPR_W);
   localparam logic [ADDR_W-1:0]  FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
   localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(NFRAMES - 1);
   localparam logic [ANC_W-1:0]   ANC_LAST = ANC_W'(ANIM_DIV - 1);

   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
      if (int'(c) > MAX_COUNT) return CNT_W'(MAX_COUNT);
      return c;
   endfunction

   logic [CNT_W-1:0] count_c;
   logic [CNT_W-1:0] blink_slot;
   logic             blink_active;
   logic             blink_on;

   assign count_c = clamp_count(count_i);

   s_sprite_blink #(
      .CNT_W      (CNT_W),
      .BLINK_LEN  (BLINK_LEN),
      .BLINK_HALF (BLINK_HALF)
   ) u_blink (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .count_c_i      (count_c),
      .frame_tick_i   (frame_tick_i),
      .blink_slot_o   (blink_slot),
      .blink_active_o (blink_active),
      .blink_on_o     (blink_on)
   );

   // Animation frame counter, advanced by frame ticks
   logic [FRM_W-1:0] anim_frame_q, anim_frame_d;
   logic [ANC_W-1:0] anim_cnt_q, anim_cnt_d;

   always_comb begin
      anim_frame_d = anim_frame_q;
      anim_cnt_d   = anim_cnt_q;
      if (frame_tick_i) begin
         if (anim_cnt_q == ANC_LAST) begin
            anim_cnt_d   = '0;
            anim_frame_d = (anim_frame_q == FRM_LAST) ? '0 : anim_frame_q + FRM_W'(1);
         end else begin
            anim_cnt_d = anim_cnt_q + ANC_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         anim_frame_q <= '0;
         anim_cnt_q   <= '0;
      end else begin
         anim_frame_q <= anim_frame_d;
         anim_cnt_q   <= anim_cnt_d;
      end
   end

   // ---- S0: combinational hit test on the current scan position ----
   scan_t                scan_p0;
   logic [SCR_Y_W-1:0]   dy_p0;
   logic                 hit_y_p0;
   logic [CMP_X_W-1:0]   x_ext_p0;
   logic [MAX_COUNT-1:0] slot_hit_p0;
   logic [CMP_X_W-1:0]   slot_off_p0 [MAX_COUNT];
   logic                 hit_x_p0;
   logic [CMP_X_W-1:0]   xoff_p0;

   assign scan_p0  = '{x: x_i, y: y_i};
   assign dy_p0    = scan_p0.y - posy_i;
   assign hit_y_p0 = (scan_p0.y >= posy_i) && (dy_p0 < SPR_H_Y);
   assign x_ext_p0 = {1'b0, scan_p0.x};

   for (genvar i = 0; i < MAX_COUNT; i++) begin : g_slot
      logic [CMP_X_W-1:0] x0;
      logic               vis;
      assign x0  = {1'b0, posx_i} + CMP_X_W'(i * PITCH);
      assign vis = (CNT_W'(i) < count_c) ||
                   (blink_active && blink_on && (blink_slot == CNT_W'(i)));
      assign slot_hit_p0[i] = vis && (x_ext_p0 >= x0) && (x_ext_p0 < x0 + SPR_W_X);
      assign slot_off_p0[i] = x_ext_p0 - x0;
   end

   // Slots never overlap (GAP >= 0), so at most one bit is set and a plain mux suffices.
   always_comb begin
      hit_x_p0 = 1'b0;
      xoff_p0  = '0;
      for (int i = 0; i < MAX_COUNT; i++) begin
         if (slot_hit_p0[i]) begin
            hit_x_p0 = 1'b1;
            xoff_p0  = slot_off_p0[i];
         end
      end
   end

   logic              hit_p1_d;
   logic [ADDR_W-1:0] rom_addr_d;

   assign hit_p1_d   = enable_i && hit_y_p0 && hit_x_p0;
   assign rom_addr_d = hit_p1_d ? (ADDR_W'(anim_frame_q) * FRAME_SZ +
                                   ADDR_W'(dy_p0) * SPR_W_A + ADDR_W'(xoff_p0))
                                : rom_addr_o;

   // ---- S1: ROM address and hit flag registered ----
   logic hit_p1_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rom_addr_o <= '0;
         hit_p1_q   <= 1'b0;
      end else begin
         rom_addr_o <= rom_addr_d;
         hit_p1_q   <= hit_p1_d;
      end
   end

   // ---- S2: ROM word arrives alongside hit_p1_q; key test and colour select ----
   logic        opaque_p2_d;
   logic [11:0] color_p2_d;
   logic        unused_rom_lsb;

   assign unused_rom_lsb = ^rom_data_i[3:0];
   assign opaque_p2_d    = hit_p1_q && px_opaque(rom_data_i[15:4], KEY);
   assign color_p2_d     = opaque_p2_d ? rom_data_i[15:4] : BG;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         color_o      <= BG;
         is_display_o <= 1'b0;
      end else begin
         color_o      <= color_p2_d;
         is_display_o <= opaque_p2_d;
      end
   end

endmodule

// File: tb/tb_s_sprite_array.sv
module tb_s_sprite_array;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  x, posx;
   logic [8:0]  y, posy;
   logic [2:0]  count;
   logic        enable, frame_tick;
   logic [15:0] rom_addr;
   logic [15:0] rom_data;
   logic [11:0] color;
   logic        is_display;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int          due;
      logic [15:0] val0;
      logic        val1;
      string       nm;
   } exp_t;

   exp_t q[$];   // colour / is_display expectations
   exp_t aq[$];  // rom_addr expectations
   exp_t mon_e;

   s_sprite_array dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .x_i          (x),
      .y_i          (y),
      .posx_i       (posx),
      .posy_i       (posy),
      .count_i      (count),
      .enable_i     (enable),
      .frame_tick_i (frame_tick),
      .rom_addr_o   (rom_addr),
      .rom_data_i   (rom_data),
      .color_o      (color),
      .is_display_o (is_display)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sprite ROM contents: address 0 holds 0x123, address 46 holds the key
   // colour, everything else holds address[11:0] ^ 0xA00.
   function automatic logic [15:0] rom_f(input logic [15:0] a);
      logic [11:0] c;
      if (a == 16'd0) return 16'h1230;
      if (a == 16'd46) return {12'h0f0, 4'h3};
      c = a[11:0] ^ 12'hA00;
      return {c, 4'h0};
   endfunction
   assign rom_data = rom_f(rom_addr);

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due < cyc) begin
         mon_e = q.pop_front();
         n_vec++; n_bad++;
         $display("FAIL %s: output not checked at cycle %0d", mon_e.nm, mon_e.due);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         mon_e = q.pop_front();
         chk({mon_e.nm, " color"}, {4'h0, color}, mon_e.val0);
         chk({mon_e.nm, " disp"}, {15'h0, is_display}, {15'h0, mon_e.val1});
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
         mon_e = aq.pop_front();
         chk({mon_e.nm, " rom_addr"}, rom_addr, mon_e.val0);
      end
   end

   task automatic pix(input int px, input int py, input logic [11:0] ec, input logic ed,
                      input string nm);
      @(negedge clk);
      x = 10'(px);
      y = 9'(py);
      q.push_back('{cyc + 2, {4'h0, ec}, ed, nm});
   endtask

   task automatic pix_a(input int px, input int py, input logic [11:0] ec, input logic ed,
                        input int ea, input string nm);
      pix(px, py, ec, ed, nm);
      aq.push_back('{cyc + 1, 16'(ea), 1'b0, nm});
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge clk) frame_tick = 1'b1;
         @(negedge clk) frame_tick = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      x = '0;
      y = '0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic set_count(input int c);
      @(negedge clk) count = 3'(c);
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; x = '0; y = '0; posx = 10'd100; posy = 9'd50;
      count = 3'd3; enable = 1'b1; frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset color", {4'h0, color}, 16'h0fff);
      chk("reset disp", {15'h0, is_display}, 16'h0);
      chk("reset rom_addr", rom_addr, 16'h0);
      @(negedge clk) rst = 1'b0;
      idle(2);

      // static geometry, animation frame 0
      pix_a(100, 50, 12'h123, 1'b1, 0, "slot0 origin");
      pix_a(101, 51, 12'hfff, 1'b0, 46, "key pixel");
      pix(144, 50, 12'hA2C, 1'b1, "slot0 last col");
      pix(145, 50, 12'hfff, 1'b0, "gap");
      pix(149, 52, 12'hA5A, 1'b1, "slot1");
      pix(99, 50, 12'hfff, 1'b0, "left of slot0");
      pix(100, 49, 12'hfff, 1'b0, "above row");
      pix(100, 92, 12'hD62, 1'b1, "last row");
      pix(100, 93, 12'hfff, 1'b0, "below row");
      pix(200, 50, 12'hA02, 1'b1, "slot2");
      pix(247, 50, 12'hfff, 1'b0, "slot3 hidden");

      // animation: frame advances on the 15th tick and wraps after 2 frames
      ticks(14);
      pix(100, 50, 12'h123, 1'b0 | 1'b1, "anim 14 ticks");
      ticks(1);
      pix_a(149, 51, 12'hDBC, 1'b1, 1980, "anim frame1 slot1");
      pix(145, 51, 12'hfff, 1'b0, "anim frame1 gap");
      ticks(15);
      pix(100, 50, 12'h123, 1'b1, "anim wrap");

      // 3 -> 2: slot 2 blinks 8 on / 8 off for 60 ticks (total ticks start at 30)
      set_count(2);
      for (int t = 0; t < 60; t++) begin
         logic vis, frm;
         vis = ((t / 8) % 2) == 0;
         frm = (((30 + t) / 15) % 2) == 1;
         pix(200, 50, vis ? (frm ? 12'hD91 : 12'hA02) : 12'hfff, vis, $sformatf("blink t=%0d", t));
         ticks(1);
      end
      pix(200, 50, 12'hfff, 1'b0, "blink over");

      // increase in idle is immediate; increase during blink returns to solid
      set_count(3);
      pix(200, 50, 12'hA02, 1'b1, "regain idle");
      set_count(2);
      ticks(8);
      pix(200, 50, 12'hfff, 1'b0, "blink off phase");
      set_count(3);
      pix(200, 50, 12'hA02, 1'b1, "regain in blink");

      // second loss while blinking restarts on the new slot (total ticks 106: frame 1)
      set_count(2);
      ticks(8);
      pix(200, 50, 12'hfff, 1'b0, "first loss off");
      set_count(1);
      pix(149, 52, 12'hDE9, 1'b1, "restart slot1 on");
      pix(200, 50, 12'hfff, 1'b0, "restart slot2 gone");
      ticks(8);
      pix(149, 52, 12'hfff, 1'b0, "restart slot1 off");

      // count 7 clamps to 5 slots, no blink
      set_count(7);
      pix(340, 50, 12'hDBB, 1'b1, "clamp slot4 last col");
      pix(341, 50, 12'hfff, 1'b0, "clamp past slot4");
      pix(345, 50, 12'hfff, 1'b0, "clamp no slot5");
      pix(149, 52, 12'hDE9, 1'b1, "clamp slot1");
      pix(247, 50, 12'hD8F, 1'b1, "clamp slot3");

      // enable low hides everything
      @(negedge clk) enable = 1'b0;
      pix(100, 50, 12'hfff, 1'b0, "disabled slot0");
      pix(340, 50, 12'hfff, 1'b0, "disabled slot4");
      @(negedge clk) enable = 1'b1;
      idle(2);

      // slot 0 near the right edge: 11-bit compares, no wrap
      @(negedge clk) posx = 10'd1000;
      idle(2);
      pix(1000, 50, 12'hD8F, 1'b1, "edge slot0 first");
      pix(1023, 50, 12'hDA6, 1'b1, "edge x=1023");
      pix(5, 50, 12'hfff, 1'b0, "edge no wrap");
      @(negedge clk) posx = 10'd100;
      idle(2);

      // asynchronous reset mid-line
      pix(100, 50, 12'hD8F, 1'b1, "pre reset");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async rst color", {4'h0, color}, 16'h0fff);
      chk("async rst disp", {15'h0, is_display}, 16'h0);
      chk("async rst rom_addr", rom_addr, 16'h0);
      @(negedge clk) rst = 1'b0;
      pix(100, 50, 12'h123, 1'b1, "after reset");
      pix(145, 50, 12'hfff, 1'b0, "after reset gap");

      for (int i = 0; i < 20 && (q.size() > 0 || aq.size() > 0); i++) @(negedge clk);
      if (q.size() > 0 || aq.size() > 0) begin
         n_vec++; n_bad++;
         $display("FAIL drain: %0d expectations never reached", q.size() + aq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
